// File: rtl/key_number_entry_if.sv
// rtl/key_number_entry_if.sv - key event input and number handshake bundle for key_number_entry
//
// Purpose: groups the PS/2 decoder outputs that key_number_entry consumes, the
//          submitted-number valid/ack handshake and the display/status outputs.
// Signals:
//   key_valid    decoder pulse: last_change just changed state
//   last_change  {extend, scancode} of the changed key
//   key_down     decoder key-state vector, indexed by last_change
//   num_ack      consumer accepts num_value
//   num_value    submitted value, stable while num_valid=1
//   num_valid    submitted value pending
//   entry_value  value currently being typed
//   entry_cnt    digits currently buffered
//   err_pulse    1-cycle pulse on a rejected action
// Modports: master drives keys/ack (decoder + game side), slave is the entry block.

interface key_number_entry_if #(
  parameter int VAL_W = 7
);
  logic             key_valid;
  logic [8:0]       last_change;
  logic [511:0]     key_down;
  logic             num_ack;
  logic [VAL_W-1:0] num_value;
  logic             num_valid;
  logic [VAL_W-1:0] entry_value;
  logic [2:0]       entry_cnt;
  logic             err_pulse;

  modport master (
    output key_valid, last_change, key_down, num_ack,
    input  num_value, num_valid, entry_value, entry_cnt, err_pulse
  );

  modport slave (
    input  key_valid, last_change, key_down, num_ack,
    output num_value, num_valid, entry_value, entry_cnt, err_pulse
  );
endinterface

// File: rtl/key_number_entry.sv
// rtl/key_number_entry.sv - turns decoded key presses into a submitted decimal number
//
// Purpose: buffers up to MAX_DIGITS decimal digits typed on a PS/2 keyboard,
//          supports Backspace/Esc editing and submits the value on Enter when it lies
//          in 1..MAX_VALUE. The submitted value is held on a valid/ack handshake.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   key_number_entry_if.slave (key events in, number handshake and status out)
// Configuration macro:
//   NUMPAD_EN  when defined, numeric keypad digit scancodes are accepted as digits.
//              Keypad Enter (15A) is accepted regardless.

module key_number_entry #(
  parameter int MAX_DIGITS = 2,
  parameter int MAX_VALUE  = 25,
  parameter int VAL_W      = 7
) (
  input  logic                clk,
  input  logic                rst,
  key_number_entry_if.slave   bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [VAL_W-1:0] r_entry_value;
  logic [2:0]       r_entry_cnt;
  logic [VAL_W-1:0] r_num_value;
  logic             r_num_valid;
  logic             r_err;

  state_t           w_state_nxt;
  logic [VAL_W-1:0] w_entry_value_nxt;
  logic [2:0]       w_entry_cnt_nxt;
  logic [VAL_W-1:0] w_num_value_nxt;
  logic             w_num_valid_nxt;
  logic             w_err_nxt;

  logic             w_press;
  logic             w_is_digit;
  logic [3:0]       w_digit;
  logic             w_is_enter;
  logic             w_is_bksp;
  logic             w_is_esc;
  logic [VAL_W-1:0] w_append;
  logic [VAL_W-1:0] w_shift;
  logic             w_in_range;

  // Only the make edge of a key counts; releases arrive with key_down cleared.
  assign w_press = bus.key_valid & bus.key_down[bus.last_change];

  // Scancode classification.
  always_comb begin
    w_is_digit = 1'b0;
    w_digit    = 4'd0;
    w_is_enter = 1'b0;
    w_is_bksp  = 1'b0;
    w_is_esc   = 1'b0;
    case (bus.last_change)
      9'h045: begin w_is_digit = 1'b1; w_digit = 4'd0; end
      9'h016: begin w_is_digit = 1'b1; w_digit = 4'd1; end
      9'h01E: begin w_is_digit = 1'b1; w_digit = 4'd2; end
      9'h026: begin w_is_digit = 1'b1; w_digit = 4'd3; end
      9'h025: begin w_is_digit = 1'b1; w_digit = 4'd4; end
      9'h02E: begin w_is_digit = 1'b1; w_digit = 4'd5; end
      9'h036: begin w_is_digit = 1'b1; w_digit = 4'd6; end
      9'h03D: begin w_is_digit = 1'b1; w_digit = 4'd7; end
      9'h03E: begin w_is_digit = 1'b1; w_digit = 4'd8; end
      9'h046: begin w_is_digit = 1'b1; w_digit = 4'd9; end
`ifdef NUMPAD_EN
      9'h070: begin w_is_digit = 1'b1; w_digit = 4'd0; end
      9'h069: begin w_is_digit = 1'b1; w_digit = 4'd1; end
      9'h072: begin w_is_digit = 1'b1; w_digit = 4'd2; end
      9'h07A: begin w_is_digit = 1'b1; w_digit = 4'd3; end
      9'h06B: begin w_is_digit = 1'b1; w_digit = 4'd4; end
      9'h073: begin w_is_digit = 1'b1; w_digit = 4'd5; end
      9'h074: begin w_is_digit = 1'b1; w_digit = 4'd6; end
      9'h06C: begin w_is_digit = 1'b1; w_digit = 4'd7; end
      9'h075: begin w_is_digit = 1'b1; w_digit = 4'd8; end
      9'h07D: begin w_is_digit = 1'b1; w_digit = 4'd9; end
`else
`endif
      9'h05A, 9'h15A: w_is_enter = 1'b1;
      9'h066:         w_is_bksp  = 1'b1;
      9'h076:         w_is_esc   = 1'b1;
      default: ;
    endcase
  end

  // Constant *10 and /10; the buffer never exceeds 10^MAX_DIGITS-1 so VAL_W holds it.
  assign w_append   = (r_entry_value * VAL_W'(10)) + VAL_W'(w_digit);
  assign w_shift    = r_entry_value / VAL_W'(10);
  assign w_in_range = (r_entry_value != '0) && (r_entry_value <= VAL_W'(MAX_VALUE));

  always_comb begin
    w_state_nxt       = r_state;
    w_entry_value_nxt = r_entry_value;
    w_entry_cnt_nxt   = r_entry_cnt;
    w_num_value_nxt   = r_num_value;
    w_num_valid_nxt   = r_num_valid;
    w_err_nxt         = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_press) begin
          if (w_is_digit) begin
            w_entry_value_nxt = VAL_W'(w_digit);
            w_entry_cnt_nxt   = 3'd1;
            w_state_nxt       = S_ENTRY;
          end else if (w_is_enter) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_ENTRY: begin
        if (w_press) begin
          if (w_is_digit) begin
            if (r_entry_cnt < 3'(MAX_DIGITS)) begin
              w_entry_value_nxt = w_append;
              w_entry_cnt_nxt   = r_entry_cnt + 3'd1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (w_is_bksp) begin
            w_entry_value_nxt = w_shift;
            w_entry_cnt_nxt   = r_entry_cnt - 3'd1;
            if (r_entry_cnt == 3'd1) begin
              w_state_nxt = S_EMPTY;
            end
          end else if (w_is_esc) begin
            w_entry_value_nxt = '0;
            w_entry_cnt_nxt   = 3'd0;
            w_state_nxt       = S_EMPTY;
          end else if (w_is_enter) begin
            if (w_in_range) begin
              // entry_value stays visible on the display until the consumer acks.
              w_num_value_nxt = r_entry_value;
              w_num_valid_nxt = 1'b1;
              w_state_nxt     = S_HOLD;
            end else begin
              w_err_nxt         = 1'b1;
              w_entry_value_nxt = '0;
              w_entry_cnt_nxt   = 3'd0;
              w_state_nxt       = S_EMPTY;
            end
          end
        end
      end
      S_HOLD: begin
        // Key events are dropped here, even when coincident with num_ack.
        if (bus.num_ack) begin
          w_num_valid_nxt   = 1'b0;
          w_entry_value_nxt = '0;
          w_entry_cnt_nxt   = 3'd0;
          w_state_nxt       = S_EMPTY;
        end
      end
      default: begin
        w_entry_value_nxt = '0;
        w_entry_cnt_nxt   = 3'd0;
        w_num_valid_nxt   = 1'b0;
        w_state_nxt       = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_EMPTY;
      r_entry_value <= '0;
      r_entry_cnt   <= 3'd0;
      r_num_value   <= '0;
      r_num_valid   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_entry_value <= w_entry_value_nxt;
      r_entry_cnt   <= w_entry_cnt_nxt;
      r_num_value   <= w_num_value_nxt;
      r_num_valid   <= w_num_valid_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign bus.num_value   = r_num_value;
  assign bus.num_valid   = r_num_valid;
  assign bus.entry_value = r_entry_value;
  assign bus.entry_cnt   = r_entry_cnt;
  assign bus.err_pulse   = r_err;

endmodule
